wb_trace_tx: RTL and testbench

Write-back trace transmitter for the processing unit. Every cycle the unit asserts `we`, the block captures the register write data `rwd` into a small FIFO. It then serializes each captured word over a UART line (8N1, MSB byte first), so a host can log the Collatz sequence the program produces. It sits beside the processing unit at top level and is the receiving end of the unit's `we`/`rwd` output port.

---
 rtl/wb_trace_tx.sv | 165 ++++++++++++++++
 tb/tb_wb_trace_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_tx.sv
// Write-back trace transmitter: captures rwd on every we into a FIFO and sends each word as 8N1 UART bytes, MSB byte first.
// Optional build macro WBT_SYNC_EN puts a 0xA5 sync byte in front of every word.
module wb_trace_tx #(
  parameter int W      = 16,
  parameter int DEPTH  = 8,
  parameter int CLKDIV = 868
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] rwd,
  output logic         txd,
  output logic         busy,
  output logic         empty,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKDIV);
  localparam int NB = W / 8;
  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [AW:0]   FULL_XOR = {1'b1, {AW{1'b0}}};
  localparam logic [BW-1:0] BAUD_TOP = BW'(CLKDIV - 1);
  localparam logic [BW-1:0] BAUD_ONE = 1;
`ifdef WBT_SYNC_EN
  localparam logic [2:0]    LAST_BYTE = 3'(NB);
`else
  localparam logic [2:0]    LAST_BYTE = 3'(NB - 1);
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          ovf_q, ovf_d, txd_q, txd_d, busy_q, busy_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d, byte_q, byte_d;
  logic [7:0]    cur_q, cur_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  mem [DEPTH];

  logic         full, pop, push;
  logic [W-1:0] head;

  assign empty = (wptr_q == rptr_q);
  assign full  = ((wptr_q ^ rptr_q) == FULL_XOR);
  assign pop   = (state_q == IDLE) && !empty;
  // A full FIFO still accepts a push when the transmitter pops on the same edge.
  assign push  = we && (!full || pop);
  assign head  = mem[rptr_q[AW-1:0]];

  assign txd  = txd_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

  always_comb begin
    state_d = state_q;
    wptr_d  = push ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d  = rptr_q;
    ovf_d   = ovf_q | (we & ~push);
    txd_d   = txd_q;
    busy_d  = busy_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    cur_d   = cur_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = START;
          rptr_d  = rptr_q + PTR_ONE;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          baud_d  = BAUD_TOP;
          byte_d  = LAST_BYTE;
`ifdef WBT_SYNC_EN
          cur_d   = 8'hA5;
          sh_d    = head;
`else
          cur_d   = head[W-1 -: 8];
          sh_d    = head << 8;
`endif
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          txd_d   = cur_q[0];
          baud_d  = BAUD_TOP;
          bit_d   = 3'd7;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_TOP;
          if (bit_q == 3'd0) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q - 3'd1;
            cur_d = cur_q >> 1;
            txd_d = cur_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (byte_q != 3'd0) begin
            state_d = START;
            txd_d   = 1'b0;
            baud_d  = BAUD_TOP;
            byte_d  = byte_q - 3'd1;
            cur_d   = sh_q[W-1 -: 8];
            sh_d    = sh_q << 8;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      cur_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      cur_q   <= cur_d;
      sh_q    <= sh_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= rwd;
  end

endmodule

// File: tb/tb_wb_trace_tx.sv
// Directed bench for wb_trace_tx (W=16, DEPTH=8, CLKDIV=4) with a UART line decoder.
module tb_wb_trace_tx;

  localparam int CD = 4;
`ifdef WBT_SYNC_EN
  localparam int NB_TX = 3;
`else
  localparam int NB_TX = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [15:0] rwd = '0;
  logic        txd, busy, empty, ovf;

  int checks = 0;
  int errors = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  wb_trace_tx #(.W(16), .DEPTH(8), .CLKDIV(CD)) dut (
    .clk(clk), .rst(rst), .we(we), .rwd(rwd),
    .txd(txd), .busy(busy), .empty(empty), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Line decoder: start seen at negedge n0, bit i sampled at n0+CD*(i+1)+1, stop at n0+9*CD+1.
  initial begin
    logic [7:0] b;
    bit abort;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        abort = 1'b0;
        b = '0;
        for (int k = 1; k <= 9*CD+1; k++) begin
          @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          if (k-1 >= CD && k-1 <= 8*CD && ((k-1) % CD) == 0) b[(k-1)/CD - 1] = txd;
          if (k == 9*CD+1 && txd !== 1'b1) frame_err++;
        end
        if (!abort) rx_q.push_back(b);
      end
    end
  end

  task automatic push_exp(input logic [15:0] w);
`ifdef WBT_SYNC_EN
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    we  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
    frame_err = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && empty) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks += 4;
      if (txd !== 1'b1)   begin errors++; $display("FAIL reset_txd cyc %0d: got %b want 1", i, txd); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy cyc %0d: got %b want 0", i, busy); end
      if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty cyc %0d: got %b want 1", i, empty); end
      if (ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf cyc %0d: got %b want 0", i, ovf); end
    end
  endtask

  task automatic test_single();
    int cnt;
    bit ok;
    apply_reset();
    push_exp(16'h001B);
    @(negedge clk);
    we = 1'b1; rwd = 16'h001B;
    @(negedge clk);
    we = 1'b0;
    checks += 3;
    if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_fall: got %b want 0", empty); end
    if (txd !== 1'b1)   begin errors++; $display("FAIL single_txd_pre: got %b want 1", txd); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL single_busy_pre: got %b want 0", busy); end
    @(negedge clk);
    checks += 2;
    if (txd !== 1'b0)  begin errors++; $display("FAIL single_txd_fall: got %b want 0", txd); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b want 1", busy); end
    cnt = 1;
    while (busy === 1'b1 && cnt < 1000) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
    end
    checks++;
    if (cnt != NB_TX*10*CD) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", cnt, NB_TX*10*CD); end
    wait_idle(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got busy=%b empty=%b want idle", busy, empty); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL single_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (frame_err != 0) begin errors++; $display("FAIL single_frame: got %0d stop errors want 0", frame_err); end
  endtask

  task automatic test_burst();
    logic [15:0] vals [5] = '{16'd27, 16'd82, 16'd41, 16'd124, 16'd62};
    bit ok;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      we = 1'b1; rwd = vals[i];
      push_exp(vals[i]);
    end
    @(negedge clk);
    we = 1'b0;
    wait_idle(3000, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL burst_timeout: got busy=%b empty=%b want idle", busy, empty); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL burst_ovf: got %b want 0", ovf); end
    if (frame_err != 0) begin errors++; $display("FAIL burst_frame: got %0d stop errors want 0", frame_err); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL burst_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL burst_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    apply_reset();
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i > 1) begin
        checks++;
        if (ovf !== 1'((i-1) >= 10)) begin errors++; $display("FAIL ovf_edge%0d: got %b want %b", i-1, ovf, (i-1) >= 10); end
      end
      we = 1'b1; rwd = 16'(i);
      if (i <= 9) push_exp(16'(i));
    end
    @(negedge clk);
    we = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_final: got %b want 1", ovf); end
    wait_idle(4000, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL ovf_timeout: got busy=%b empty=%b want idle", busy, empty); end
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    if (frame_err != 0) begin errors++; $display("FAIL ovf_frame: got %0d stop errors want 0", frame_err); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_pop();
    bit ok;
    int n;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      we = 1'b1; rwd = 16'h1000 + 16'(i);
      push_exp(16'h1000 + 16'(i));
    end
    @(negedge clk);
    we = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL fullpop_idle_timeout: got busy=%b want 0", busy); end
    if (empty !== 1'b0) begin errors++; $display("FAIL fullpop_nonempty: got empty=%b want 0", empty); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf_pre: got %b want 0", ovf); end
    we = 1'b1; rwd = 16'h100A;
    push_exp(16'h100A);
    @(negedge clk);
    we = 1'b0;
    checks += 2;
    if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", ovf); end
    if (busy !== 1'b1) begin errors++; $display("FAIL fullpop_busy: got %b want 1", busy); end
    wait_idle(4000, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL fullpop_timeout: got busy=%b empty=%b want idle", busy, empty); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf_end: got %b want 0", ovf); end
    if (frame_err != 0) begin errors++; $display("FAIL fullpop_frame: got %0d stop errors want 0", frame_err); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL fullpop_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL fullpop_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    @(negedge clk);
    we = 1'b1; rwd = 16'h1234;
    @(negedge clk);
    we = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (txd !== 1'b1)   begin errors++; $display("FAIL rstmid_txd: got %b want 1", txd); end
    if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b want 1", empty); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
    frame_err = 0;
    repeat (5) @(negedge clk);
    checks += 2;
    if (txd !== 1'b1)  begin errors++; $display("FAIL rstmid_no_resume_txd: got %b want 1", txd); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_resume_busy: got %b want 0", busy); end
    we = 1'b1; rwd = 16'h0005;
    push_exp(16'h0005);
    @(negedge clk);
    we = 1'b0;
    wait_idle(1000, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: got busy=%b empty=%b want idle", busy, empty); end
    if (frame_err != 0) begin errors++; $display("FAIL rstmid_frame: got %0d stop errors want 0", frame_err); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
